uart_mmio_ctrl: RTL and testbench

UART_MMIO_CTRL -- requirements
Module: uart_mmio_ctrl

---
 rtl/riscv_mmio_pkg.sv | 27 ++
 rtl/sync_fifo.sv | 54 +++++
 rtl/uart_mmio_ctrl.sv | 113 +++++++++++
 tb/tb_uart_mmio_ctrl.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_mmio_pkg.sv
// Shared MMIO register map and status-word layout for the UART/counter peripheral.
// Offsets are relative to the instance's MMIO base address.
package riscv_mmio_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned BYTE_W    = 8;

    localparam logic [31:0] OFF_STATUS  = 32'h0000_0000;
    localparam logic [31:0] OFF_RXDATA  = 32'h0000_0004;
    localparam logic [31:0] OFF_TXDATA  = 32'h0000_0008;
    localparam logic [31:0] OFF_CYCLE   = 32'h0000_0010;
    localparam logic [31:0] OFF_INSTRET = 32'h0000_0014;
    localparam logic [31:0] OFF_CNTCLR  = 32'h0000_0018;

    localparam int unsigned STAT_TX_FREE_BIT     = 0;
    localparam int unsigned STAT_RX_NONEMPTY_BIT = 1;

    // Assemble the status word; all other bits read as zero.
    function automatic logic [XLEN-1:0] status_word(input logic rx_nonempty, input logic tx_free);
        logic [XLEN-1:0] s;
        s = '0;
        s[STAT_RX_NONEMPTY_BIT] = rx_nonempty;
        s[STAT_TX_FREE_BIT]     = tx_free;
        return s;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead output: dout shows the head entry whenever !empty.
// Writes when full and reads when empty are ignored.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wptr_q, wptr_d;
    logic [PW-1:0]    rptr_q, rptr_d;
    logic             do_wr;
    logic             do_rd;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign do_wr = wr_en && !full;
    assign do_rd = rd_en && !empty;
    assign dout  = mem_q[rptr_q[AW-1:0]];

    always_comb begin
        wptr_d = wptr_q + PW'(do_wr);
        rptr_d = rptr_q + PW'(do_rd);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_q[wptr_q[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/uart_mmio_ctrl.sv
// Memory-mapped UART bridge with cycle/instruction counters for a small RISC-V core.
// RX bytes are buffered in a FIFO; TX uses a single holding register.
module uart_mmio_ctrl
    import riscv_mmio_pkg::*;
#(
    parameter int unsigned RX_FIFO_DEPTH = 8,
    parameter logic [31:0] MMIO_BASE     = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic        re,
    input  logic        we,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    input  logic        inst_retired,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready
);

    logic [31:0]       off;
    logic [31:0]       rdata_q, rdata_d;
    logic [31:0]       cyc_q, cyc_d;
    logic [31:0]       inst_q, inst_d;
    logic [BYTE_W-1:0] tx_data_q, tx_data_d;
    logic              tx_valid_q, tx_valid_d;
    logic              fifo_full;
    logic              fifo_empty;
    logic [BYTE_W-1:0] fifo_dout;
    logic              rx_push;
    logic              rx_pop;
    logic              cnt_clr;
    logic              unused_wdata;

    assign off          = addr - MMIO_BASE;
    assign rx_ready     = !fifo_full;
    assign rx_push      = rx_valid && !fifo_full;
    assign rx_pop       = re && (off == OFF_RXDATA) && !fifo_empty;
    assign cnt_clr      = we && (off == OFF_CNTCLR);
    assign unused_wdata = ^wdata[31:BYTE_W];

    sync_fifo #(
        .WIDTH (BYTE_W),
        .DEPTH (RX_FIFO_DEPTH)
    ) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .wr_en (rx_push),
        .din   (rx_data),
        .full  (fifo_full),
        .rd_en (rx_pop),
        .dout  (fifo_dout),
        .empty (fifo_empty)
    );

    // Load data path: result holds until the next load strobe.
    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            case (off)
                OFF_STATUS:  rdata_d = status_word(!fifo_empty, !tx_valid_q);
                OFF_RXDATA:  rdata_d = fifo_empty ? '0 : {24'b0, fifo_dout};
                OFF_CYCLE:   rdata_d = cyc_q;
                OFF_INSTRET: rdata_d = inst_q;
                default:     rdata_d = '0;
            endcase
        end
    end

    // A store arriving while a byte is pending (even on its handshake cycle) is dropped.
    always_comb begin
        tx_valid_d = tx_valid_q;
        tx_data_d  = tx_data_q;
        if (tx_valid_q) begin
            if (tx_ready) begin
                tx_valid_d = 1'b0;
            end
        end else if (we && (off == OFF_TXDATA)) begin
            tx_valid_d = 1'b1;
            tx_data_d  = wdata[BYTE_W-1:0];
        end
    end

    always_comb begin
        cyc_d  = cnt_clr ? '0 : cyc_q + 32'd1;
        inst_d = cnt_clr ? '0 : inst_q + 32'(inst_retired);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q    <= '0;
            cyc_q      <= '0;
            inst_q     <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
        end else begin
            rdata_q    <= rdata_d;
            cyc_q      <= cyc_d;
            inst_q     <= inst_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
        end
    end

    assign rdata    = rdata_q;
    assign tx_data  = tx_data_q;
    assign tx_valid = tx_valid_q;

endmodule

// File: tb/tb_uart_mmio_ctrl.sv
// Bench for uart_mmio_ctrl: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_uart_mmio_ctrl;

    localparam logic [31:0] BASE  = 32'h8000_0000;
    localparam int          DEPTH = 8;

    logic        clk;
    logic        rst;
    logic [31:0] addr;
    logic        re;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        inst_retired;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 0;

    uart_mmio_ctrl #(
        .RX_FIFO_DEPTH (DEPTH),
        .MMIO_BASE     (BASE)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .addr         (addr),
        .re           (re),
        .we           (we),
        .wdata        (wdata),
        .rdata        (rdata),
        .inst_retired (inst_retired),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    logic [7:0]  m_q [$];
    logic [31:0] m_rdata;
    logic [31:0] m_cyc;
    logic [31:0] m_inst;
    logic        m_txv;
    logic [7:0]  m_txd;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_q.delete();
            m_rdata = '0;
            m_cyc   = '0;
            m_inst  = '0;
            m_txv   = 1'b0;
            m_txd   = '0;
        end else begin
            logic [31:0] off;
            int          sz;
            off = addr - BASE;
            sz  = m_q.size();
            if (re) begin
                if (off == 32'h00)      m_rdata = {30'b0, sz != 0, !m_txv};
                else if (off == 32'h04) begin
                    if (sz > 0) begin
                        m_rdata = {24'b0, m_q[0]};
                        void'(m_q.pop_front());
                    end else begin
                        m_rdata = '0;
                    end
                end
                else if (off == 32'h10) m_rdata = m_cyc;
                else if (off == 32'h14) m_rdata = m_inst;
                else                    m_rdata = '0;
            end
            if (rx_valid && sz < DEPTH) m_q.push_back(rx_data);
            if (m_txv) begin
                if (tx_ready) m_txv = 1'b0;
            end else if (we && off == 32'h08) begin
                m_txv = 1'b1;
                m_txd = wdata[7:0];
            end
            if (we && off == 32'h18) begin
                m_cyc  = '0;
                m_inst = '0;
            end else begin
                m_cyc  = m_cyc + 32'd1;
                m_inst = m_inst + 32'(inst_retired);
            end
        end
    end

    // Independent count of handshakes seen on the DUT's TX port
    int         dut_hs = 0;
    logic [7:0] dut_last_tx = '0;
    always @(posedge clk) begin
        if (!rst && tx_valid && tx_ready) begin
            dut_hs      <= dut_hs + 1;
            dut_last_tx <= tx_data;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("model_rdata",    rdata,           m_rdata);
            chk("model_tx_valid", 32'(tx_valid),   32'(m_txv));
            chk("model_tx_data",  32'(tx_data),    32'(m_txd));
            chk("model_rx_ready", 32'(rx_ready),   32'(m_q.size() < DEPTH));
        end
    end

    // All stimulus tasks start and end one time unit after a rising edge.
    task automatic cycle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic load(input logic [31:0] off, output logic [31:0] val);
        addr = BASE + off;
        re   = 1'b1;
        cycle(1);
        re   = 1'b0;
        val  = rdata;
    endtask

    task automatic store(input logic [31:0] off, input logic [31:0] data);
        addr  = BASE + off;
        wdata = data;
        we    = 1'b1;
        cycle(1);
        we    = 1'b0;
    endtask

    logic [31:0] offs [8] = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h14, 32'h18, 32'h1C};

    initial begin
        logic [31:0] v;
        logic [31:0] a;
        int          h0;

        rst = 1'b1; re = 1'b0; we = 1'b0; addr = BASE; wdata = '0;
        inst_retired = 1'b0; tx_ready = 1'b0; rx_valid = 1'b0; rx_data = '0;
        cycle(2);
        cmp_en = 1;
        chk("reset_rdata",    rdata,           32'h0);
        chk("reset_tx_valid", 32'(tx_valid),   32'h0);
        chk("reset_tx_data",  32'(tx_data),    32'h0);
        chk("reset_rx_ready", 32'(rx_ready),   32'h1);
        rst = 1'b0;

        // Status and cycle counter after reset
        load(32'h00, v);  chk("status_after_reset", v, 32'h1);
        load(32'h10, a);
        cycle(4);
        load(32'h10, v);  chk("cycle_delta_5", v - a, 32'd5);

        // Two RX bytes
        rx_valid = 1'b1; rx_data = 8'h7A; cycle(1);
        rx_data  = 8'h41; cycle(1);
        rx_valid = 1'b0;
        load(32'h00, v);  chk("status_rx_two", v, 32'h3);
        load(32'h04, v);  chk("rx_first",  v, 32'h7A);
        load(32'h04, v);  chk("rx_second", v, 32'h41);
        load(32'h00, v);  chk("status_rx_drained", v, 32'h1);
        load(32'h04, v);  chk("rx_empty_load", v, 32'h0);

        // Fill FIFO, overflow byte is refused
        for (int i = 0; i < DEPTH; i++) begin
            rx_valid = 1'b1; rx_data = 8'(i); cycle(1);
        end
        rx_data = 8'h99;
        chk("rx_ready_full", 32'(rx_ready), 32'h0);
        cycle(1);
        rx_valid = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            load(32'h04, v); chk("rx_fill_order", v, 32'(i));
        end
        load(32'h04, v);  chk("rx_after_drain", v, 32'h0);

        // TX hold, drop, single handshake
        tx_ready = 1'b0;
        store(32'h08, 32'h0000_007A);
        for (int i = 0; i < 10; i++) begin
            chk("tx_hold_valid", 32'(tx_valid), 32'h1);
            chk("tx_hold_data",  32'(tx_data),  32'h7A);
            cycle(1);
        end
        store(32'h08, 32'h0000_0055);
        chk("tx_drop_data", 32'(tx_data), 32'h7A);
        load(32'h00, v);  chk("status_tx_busy", v, 32'h0);
        h0 = dut_hs;
        tx_ready = 1'b1;
        cycle(1);
        chk("tx_fall", 32'(tx_valid), 32'h0);
        tx_ready = 1'b0;
        cycle(2);
        chk("tx_one_handshake", 32'(dut_hs - h0), 32'h1);
        chk("tx_handshake_byte", 32'(dut_last_tx), 32'h7A);

        // Instruction counter and clear-wins-over-increment
        store(32'h18, 32'h0);
        for (int i = 0; i < 3; i++) begin
            inst_retired = 1'b1; cycle(1);
            inst_retired = 1'b0; cycle(1);
        end
        load(32'h14, v);  chk("instret_three", v, 32'd3);
        for (int i = 0; i < 3; i++) begin
            inst_retired = 1'b1; cycle(1);
            inst_retired = 1'b0; cycle(1);
        end
        inst_retired = 1'b1;
        store(32'h18, 32'hDEAD_BEEF);
        inst_retired = 1'b0;
        load(32'h14, v);  chk("instret_cleared", v, 32'h0);
        load(32'h10, v);  chk("cycle_after_clear", v, 32'h1);

        // Reset with RX data and pending TX
        rx_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rx_data = 8'(8'h11 * (i + 1)); cycle(1);
        end
        rx_valid = 1'b0;
        store(32'h08, 32'h0000_00C3);
        chk("tx_pending_pre_rst", 32'(tx_valid), 32'h1);
        rst = 1'b1;
        #1;
        chk("rst_async_tx_valid", 32'(tx_valid), 32'h0);
        chk("rst_async_rx_ready", 32'(rx_ready), 32'h1);
        cycle(2);
        rst = 1'b0;
        load(32'h00, v);  chk("status_after_mid_rst", v, 32'h1);
        chk("tx_valid_after_mid_rst", 32'(tx_valid), 32'h0);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            re           = ($urandom_range(0, 2) == 0);
            we           = ($urandom_range(0, 4) == 0);
            addr         = ($urandom_range(0, 15) == 0) ? $urandom : BASE + offs[$urandom_range(0, 7)];
            if (we && addr == BASE + 32'h18 && $urandom_range(0, 3) != 0) we = 1'b0;
            wdata        = $urandom;
            rx_valid     = ($urandom_range(0, 2) == 0);
            rx_data      = 8'($urandom);
            tx_ready     = ($urandom_range(0, 3) == 0);
            inst_retired = 1'($urandom_range(0, 1));
            rst          = ($urandom_range(0, 599) == 0);
            cycle(1);
        end
        rst = 1'b0; re = 1'b0; we = 1'b0; rx_valid = 1'b0;
        cycle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
